// File: rtl/uart_if.sv
// uart_if: byte-level front-end bus between a register/bus block and uart_core
interface uart_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overflow;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_overflow
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_overflow
    );
endinterface

// File: rtl/uart_core.sv
// uart_core: 8N1 LSB-first UART with fixed-divider TX/RX and a first-word-fall-through RX FIFO
module uart_core #(
    parameter int BAUD     = 115200,
    parameter int FREQ     = 50000000,
    parameter int RX_DEPTH = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    uart_if.slave  bus,
    output logic   tx_o,
    input  logic   rx_i
);
    localparam int CPS = FREQ / BAUD;
    localparam int CW  = $clog2(CPS);
    localparam int AW  = $clog2(RX_DEPTH);
    localparam int PW  = AW + 1;

    if (CPS < 4) begin : g_cps_chk
        $fatal(1, "uart_core: FREQ/BAUD must be at least 4");
    end
    if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_depth_chk
        $fatal(1, "uart_core: RX_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_last, tx_accept;

    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic              rx_ferr_q, rx_ferr_d, rx_ovf_q, rx_ovf_d;
    logic              rx_last, rx_push;

    logic [7:0]        mem_q [RX_DEPTH];
    logic [7:0]        mem_d [RX_DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic              empty, full, pop, wr_en;

    assign tx_last      = tx_cnt_q == CW'(CPS - 1);
    assign bus.tx_ready = (tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_last);
    assign bus.tx_busy  = tx_state_q != TX_IDLE;
    assign tx_accept    = bus.tx_valid && bus.tx_ready;
    assign tx_o         = tx_line_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_accept) begin
                    tx_state_d = TX_START;
                    tx_shift_d = bus.tx_data;
                end
            end
            TX_START: if (tx_last) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_last) begin
                tx_cnt_d   = '0;
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_state_d = tx_bit_q == 3'd7 ? TX_STOP : TX_DATA;
            end
            TX_STOP: if (tx_last) begin
                tx_cnt_d   = '0;
                tx_state_d = tx_accept ? TX_START : TX_IDLE;
                tx_shift_d = tx_accept ? bus.tx_data : tx_shift_q;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // The line is registered from the next state so tx_o is glitch-free
        tx_line_d = tx_state_d == TX_START ? 1'b0 : tx_state_d == TX_DATA ? tx_shift_d[0] : 1'b1;
    end

    assign rx_last = rx_cnt_q == CW'(CPS - 1);

    always_comb begin
        rx_meta_d  = rx_i;
        rx_s_d     = rx_meta_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d   = '0;
                rx_state_d = rx_s_q ? RX_IDLE : RX_START;
            end
            RX_START: if (rx_cnt_q == CW'(CPS / 2 - 1)) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_last) begin
                rx_cnt_d   = '0;
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                rx_state_d = rx_bit_q == 3'd7 ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (rx_last) begin
                rx_cnt_d   = '0;
                rx_push    = rx_s_q;
                rx_ferr_d  = !rx_s_q;
                rx_state_d = rx_s_q ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                rx_cnt_d   = '0;
                rx_state_d = rx_s_q ? RX_IDLE : RX_BREAK;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign empty        = wr_q == rd_q;
    assign full         = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop          = !empty && bus.rx_ready;
    assign bus.rx_valid = !empty;
    assign bus.rx_data  = mem_q[rd_q[AW-1:0]];
    assign bus.rx_frame_err = rx_ferr_q;
    assign bus.rx_overflow  = rx_ovf_q;

    always_comb begin
        // A same-cycle pop frees the slot, so a full FIFO can still take the byte
        wr_en    = rx_push && (!full || pop);
        rx_ovf_d = rx_push && full && !pop;
        wr_d     = wr_q + PW'(wr_en);
        rd_d     = rd_q + PW'(pop);
        mem_d    = mem_q;
        if (wr_en) mem_d[wr_q[AW-1:0]] = rx_shift_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_ferr_q  <= 1'b0;
            rx_ovf_q   <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovf_q   <= rx_ovf_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule
